// File: rtl/if_stage_pkg.sv
// Shared CPU definitions used by the instruction-fetch stage: word width,
// reset vector, the fetch-buffer entry record and the fetch FSM encoding.
package if_stage_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int FIFO_DEPTH = 2;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
        logic              adel;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } fetch_state_t;

    function automatic logic pc_misaligned(input logic [WORD_W-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer between instruction memory and decode.
// clear wins over push/pop; a push alongside clear lands as the only entry.
module fetch_fifo
    import if_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [1:0]         count
);

    fetch_entry_t mem [FIFO_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= push;
            count  <= {1'b0, push};
            if (push) begin
                mem[0] <= fetch_entry_t'(din);
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= fetch_entry_t'(din);
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues one memory request at a time, buffers up to
// two fetched words, and handles redirects, stale responses and bad targets.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic              clk,
    input  logic              reset,
    output logic              inst_req,
    output logic [WORD_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [WORD_W-1:0] inst_rdata,
    output logic              if_valid,
    input  logic              id_ready,
    output logic [WORD_W-1:0] if_pc,
    output logic [WORD_W-1:0] if_inst,
    output logic              if_adel,
    input  logic              flush,
    input  logic [WORD_W-1:0] flush_pc,
    output logic [1:0]        dbg_state
);

    fetch_state_t      state;
    logic [WORD_W-1:0] fetch_pc;
    logic [WORD_W-1:0] req_pc;
    logic              discard;

    logic               fifo_full;
    logic               fifo_empty;
    logic [1:0]         fifo_count;
    logic [ENTRY_W-1:0] head_bits;
    fetch_entry_t       head_entry;
    fetch_entry_t       push_entry;

    logic outstanding;
    logic room;
    logic accept;
    logic stale_after_flush;
    logic push;
    logic pop;

    // Handshakes: a request transfers on inst_req & inst_addr_ok, a response on
    // inst_data_ok, and a buffered entry on if_valid & id_ready, all at posedge.
    assign outstanding = (state == S_WAIT) || discard;
    assign room        = ({1'b0, fifo_count} + {2'b00, outstanding}) < 3'd2;
    assign inst_req    = reset && (state == S_REQ) && !fifo_full && room;
    assign accept      = inst_req && inst_addr_ok;
    assign inst_addr   = fetch_pc;

    // A redirect leaves an in-flight response behind whenever one is pending
    // past this edge; that response must later be thrown away.
    assign stale_after_flush = (outstanding && !inst_data_ok) || accept;

    assign pop = if_valid && id_ready && !flush;

    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (flush) begin
            push            = pc_misaligned(flush_pc);
            push_entry.pc   = flush_pc;
            push_entry.adel = 1'b1;
        end else begin
            push            = (state == S_WAIT) && inst_data_ok && !discard;
            push_entry.pc   = req_pc;
            push_entry.inst = inst_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            discard  <= 1'b0;
        end else if (flush) begin
            fetch_pc <= flush_pc;
            discard  <= stale_after_flush;
            if (accept) begin
                req_pc <= fetch_pc;
            end
            if (pc_misaligned(flush_pc)) begin
                state <= S_HALT;
            end else if (stale_after_flush) begin
                state <= S_WAIT;
            end else begin
                state <= S_REQ;
            end
        end else begin
            if (inst_data_ok && outstanding) begin
                discard <= 1'b0;
            end
            case (state)
                S_REQ: begin
                    if (accept) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_entry = fetch_entry_t'(head_bits);
    assign if_valid   = !fifo_empty;
    assign if_pc      = head_entry.pc;
    assign if_inst    = head_entry.inst;
    assign if_adel    = if_valid && head_entry.adel;
    assign dbg_state  = state;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: randomized memory/decode/redirect stimulus, with the
// expected instruction stream kept as a queue of {pc, inst, adel} entries.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] STALE  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;
    logic        flush;
    logic [31:0] flush_pc;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .if_valid     (if_valid),
        .id_ready     (id_ready),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_adel      (if_adel),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .dbg_state    (dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    int n_consumed = 0;

    logic [64:0] exp_q[$];
    logic [31:0] stream_pc = RST_PC;
    bit          halted = 0;

    // memory model
    bit          pend = 0;
    logic [31:0] pend_addr = '0;
    bit          pend_stale = 0;
    int          pend_delay = 0;

    int          ok_pct = 0;
    int          rdy_pct = 0;
    int          min_dly = 0;
    int          max_dly = 0;
    bit          want_flush = 0;
    logic [31:0] want_pc = '0;
    bit          flush_at_dok = 0;
    bit          drv_reset_low = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, then drive the next cycle's inputs.
    task automatic step();
        bit          s_acc;
        bit          s_dok;
        bit          s_flush;
        bit          s_rst;
        logic [31:0] s_addr;
        @(negedge clk);
        s_acc   = reset && inst_req && inst_addr_ok;
        s_addr  = inst_addr;
        s_dok   = inst_data_ok;
        s_flush = flush;
        s_rst   = reset;
        @(posedge clk);
        #1;
        if (!s_rst) begin
            pend = 0;
        end else begin
            if (s_dok) pend = 0;
            if (pend && s_flush) pend_stale = 1;
            if (pend && pend_delay > 0) pend_delay--;
            if (s_acc) begin
                pend       = 1;
                pend_addr  = s_addr;
                pend_stale = s_flush;
                pend_delay = $urandom_range(max_dly, min_dly);
            end
        end
        reset        = !drv_reset_low;
        flush        = 0;
        flush_pc     = $urandom;
        inst_data_ok = 0;
        inst_rdata   = $urandom;
        if (pend && pend_delay == 0) begin
            inst_data_ok = 1;
            inst_rdata   = (pend_stale || !reset) ? STALE : mem_word(pend_addr);
            if (flush_at_dok && reset) begin
                want_flush   = 1;
                flush_at_dok = 0;
            end
        end
        if (want_flush && reset) begin
            flush      = 1;
            flush_pc   = want_pc;
            want_flush = 0;
            if (inst_data_ok) inst_rdata = STALE;
            exp_q.delete();
            if (want_pc[1:0] != 2'b00) begin
                exp_q.push_back({want_pc, 32'h0, 1'b1});
                halted = 1;
            end else begin
                halted    = 0;
                stream_pc = want_pc;
            end
        end
        if (!reset) begin
            exp_q.delete();
            halted    = 0;
            stream_pc = RST_PC;
        end
        if (!halted) begin
            while (exp_q.size() < 8) begin
                exp_q.push_back({stream_pc, mem_word(stream_pc), 1'b0});
                stream_pc = stream_pc + 32'd4;
            end
        end
        inst_addr_ok = ($urandom_range(99, 0) < ok_pct);
        id_ready     = ($urandom_range(99, 0) < rdy_pct);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_pend(input string name);
        int n;
        n = 0;
        while (!pend && n < 40) begin
            step();
            n++;
        end
        check({name, "_pend_timeout"}, pend, 1);
    endtask

    // Monitor: compares every entry decode consumes against the queue head.
    always @(negedge clk) begin
        if (reset) begin
            if (pend || inst_data_ok) check("one_outstanding", inst_req, 0);
            if (halted && !flush) check("halt_no_req", inst_req, 0);
            if (if_valid && id_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_entry: got pc=%h inst=%h expected no entry", if_pc, if_inst);
                end else begin
                    check("head_entry", {if_pc, if_inst, if_adel}, exp_q.pop_front());
                end
                n_consumed++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int          kind;
        int          base;

        reset = 0; flush = 0; flush_pc = '0; inst_addr_ok = 0;
        inst_data_ok = 0; inst_rdata = '0; id_ready = 0;

        // reset values
        drv_reset_low = 1;
        run(3);
        #1;
        check("rst_if_valid", if_valid, 0);
        check("rst_if_adel", if_adel, 0);
        check("rst_inst_req", inst_req, 0);
        check("rst_inst_addr", inst_addr, RST_PC);
        drv_reset_low = 0;
        step();
        #1;
        check("post_rst_inst_req", inst_req, 1);
        check("post_rst_inst_addr", inst_addr, RST_PC);

        // zero-wait memory, decode always ready
        ok_pct = 100; rdy_pct = 100; min_dly = 0; max_dly = 0;
        base = n_consumed;
        run(12);
        check("zero_wait_progress", (n_consumed - base) >= 3, 1);

        // decode stalled: buffer fills to two, requests stop
        rdy_pct = 0;
        run(10);
        #1;
        check("stall_inst_req", inst_req, 0);
        check("stall_if_valid", if_valid, 1);
        ok_pct = 0; rdy_pct = 100;
        base = n_consumed;
        run(5);
        check("stall_buffered_count", n_consumed - base, 2);
        #1;
        check("drained_inst_req", inst_req, 1);

        // redirect while waiting on a slow response
        ok_pct = 100; min_dly = 3; max_dly = 3;
        wait_pend("wait_flush");
        want_pc = 32'h8000_0180; want_flush = 1;
        base = n_consumed;
        run(20);
        check("wait_flush_progress", (n_consumed - base) >= 2, 1);

        // redirect in the same cycle as a response
        min_dly = 1; max_dly = 1;
        wait_pend("dok_flush");
        want_pc = 32'h8000_1000; flush_at_dok = 1;
        base = n_consumed;
        run(20);
        check("dok_flush_progress", (n_consumed - base) >= 2, 1);

        // misaligned target: one exception entry, then halt
        min_dly = 0; max_dly = 0; rdy_pct = 0;
        want_pc = 32'h8000_0002; want_flush = 1;
        run(2);
        #1;
        check("adel_if_valid", if_valid, 1);
        check("adel_if_adel", if_adel, 1);
        check("adel_if_pc", if_pc, 32'h8000_0002);
        check("adel_inst_req", inst_req, 0);
        run(5);
        #1;
        check("halt_inst_req", inst_req, 0);
        rdy_pct = 100;
        run(3);
        #1;
        check("halt_drained", if_valid, 0);
        want_pc = 32'h8000_2000; want_flush = 1;
        run(10);

        // address wrap at the top of memory
        want_pc = 32'hFFFF_FFF8; want_flush = 1;
        base = n_consumed;
        run(16);
        check("wrap_progress", (n_consumed - base) >= 3, 1);

        // reset in the middle of a transaction
        min_dly = 3; max_dly = 3;
        wait_pend("mid_reset");
        drv_reset_low = 1;
        run(2);
        #1;
        check("mid_rst_inst_req", inst_req, 0);
        check("mid_rst_if_valid", if_valid, 0);
        check("mid_rst_inst_addr", inst_addr, RST_PC);
        drv_reset_low = 0; ok_pct = 0;
        step();
        #1;
        check("mid_rst_rel_inst_req", inst_req, 1);
        check("mid_rst_rel_inst_addr", inst_addr, RST_PC);
        check("mid_rst_rel_empty", if_valid, 0);

        // randomized traffic with redirects and resets
        ok_pct = 60; rdy_pct = 70; min_dly = 0; max_dly = 3;
        base = n_consumed;
        for (int i = 0; i < 3000; i++) begin
            if (drv_reset_low) begin
                drv_reset_low = 0;
            end else if ($urandom_range(199, 0) == 0) begin
                drv_reset_low = 1;
            end else if (!want_flush && !flush_at_dok && $urandom_range(32, 0) == 0) begin
                r    = $urandom;
                kind = $urandom_range(9, 0);
                if (kind == 0) want_pc = 32'hFFFF_FFF4;
                else if (kind == 1) want_pc = {r[31:2], (r[1:0] == 2'b00) ? 2'b01 : r[1:0]};
                else want_pc = {r[31:2], 2'b00};
                if (kind == 2 && pend) flush_at_dok = 1;
                else want_flush = 1;
            end
            step();
        end
        check("random_progress", (n_consumed - base) > 100, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'hBFC0_0000, first fetch address after reset.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; asserted when 0.
REQ-004 inst_req  output  1  instruction-memory request valid.
REQ-005 inst_addr  output  32  instruction-memory byte address.
REQ-006 inst_addr_ok  input  1  memory accepts request this cycle.
REQ-007 inst_data_ok  input  1  memory returns read data this cycle.
REQ-008 inst_rdata  input  32  returned instruction word.
REQ-009 if_valid  output  1  fetch-buffer head valid toward decode.
REQ-010 id_ready  input  1  decode consumes head this cycle.
REQ-011 if_pc  output  32  PC of head entry.
REQ-012 if_inst  output  32  instruction of head entry.
REQ-013 if_adel  output  1  head entry is a misaligned-fetch exception.
REQ-014 flush  input  1  redirect request (branch or exception).
REQ-015 flush_pc  input  32  redirect target.

Function
REQ-016 FSM states: REQ (inst_req=1), WAIT (one request accepted, data pending), HALT (misaligned target, no fetching).
REQ-017 REQ -> WAIT on inst_addr_ok=1; WAIT -> REQ on inst_data_ok=1; no new request issued in the same cycle as inst_data_ok.
REQ-018 At most one request outstanding; inst_req asserted only when buffer occupancy plus outstanding count is below 2.
REQ-019 inst_addr holds stable while inst_req=1 and inst_addr_ok=0, except when replaced by a flush.
REQ-020 Fetch PC advances by 4 on each accepted request; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-021 Accepted data, non-discarded, is pushed with its PC into a 2-entry FIFO; if_valid is driven from the FIFO head the cycle after inst_data_ok.
REQ-022 Pop occurs when if_valid=1 and id_ready=1; push and pop in the same cycle are both performed; occupancy is never exceeded per REQ-018.
REQ-023 flush has highest priority: FIFO cleared and fetch PC = flush_pc on the next cycle; if_valid=0 in the next cycle.
REQ-024 flush during WAIT, or coinciding with inst_addr_ok=1, sets a discard flag; the next inst_data_ok is dropped and clears the flag.
REQ-025 flush coinciding with inst_data_ok: that data is dropped and no discard flag is set.
REQ-026 flush in REQ with inst_addr_ok=0: inst_addr is replaced by flush_pc in the next cycle without deasserting inst_req.
REQ-027 flush_pc[1:0] != 0: no memory request; push one entry {pc=flush_pc, inst=0, adel=1} and enter HALT; only a later flush leaves HALT.
REQ-028 A flush while the discard flag is already set keeps the flag set; one pending response is still dropped.

Reset
REQ-029 While reset=0: state=REQ, fetch PC=RESET_PC, FIFO empty, discard=0.
REQ-030 Output values while reset=0: if_valid=0, if_adel=0, inst_req=0, inst_addr=RESET_PC.
REQ-031 First cycle after reset=1: inst_req=1, inst_addr=RESET_PC.
REQ-032 Reset asserted mid-transaction abandons the outstanding request; responses are ignored until reset is released.

Structure
REQ-033 Shared CPU package holds: RESET_PC default, the 32-bit word width, and the fetch-entry record {pc[31:0], inst[31:0], adel}.
REQ-034 FIFO is a sub-module fetch_fifo: 2 entries, with push, pop, clear, full, empty and count outputs.

Verification
REQ-035 Zero-wait memory (addr_ok=1, data_ok one cycle later), id_ready=1 -> if_pc sequence BFC00000, BFC00004, BFC00008 with matching if_inst.
REQ-036 id_ready=0 for 10 cycles -> exactly 2 entries buffered, inst_req=0, no entry lost when id_ready returns to 1.
REQ-037 flush_pc=8000_0180 while in WAIT, stale data_ok with rdata=DEADBEEF -> DEADBEEF never appears; next if_pc=8000_0180.
REQ-038 flush coinciding with inst_data_ok -> data dropped, next accepted response delivered normally.
REQ-039 flush_pc=8000_0002 -> if_valid=1, if_adel=1, if_pc=8000_0002, inst_req stays 0 until the next flush.
REQ-040 reset=0 asserted during WAIT, then released -> inst_req=1, inst_addr=BFC00000, FIFO empty.
